// File: rtl/enigma_pkg.sv
// enigma_pkg: shared constants and helpers for the fixed Enigma I machine.
// Holds the alphabet size, letter-index type, rotor (I, II, III) forward and
// inverse wiring tables, reflector B, turnover notches and mod-26 helpers.
// Letter indices are 0..25 for A..Z throughout.
package enigma_pkg;

    localparam logic [5:0] ALPHA_SIZE  = 6'd26;

    typedef logic [4:0] letter_t;

    localparam letter_t    LAST_LETTER = 5'd25;

    typedef enum logic [1:0] {
        ROTOR_I   = 2'd0,
        ROTOR_II  = 2'd1,
        ROTOR_III = 2'd2
    } rotor_id_e;

    // Turnover notches: Q, E, V
    localparam letter_t NOTCH_I   = 5'd16;
    localparam letter_t NOTCH_II  = 5'd4;
    localparam letter_t NOTCH_III = 5'd21;

    // Rotor I: EKMFLGDQVZNTOWYHXUSPAIBRCJ
    localparam letter_t WIRE_I_FWD [26] = '{
        5'd4,  5'd10, 5'd12, 5'd5,  5'd11, 5'd6,  5'd3,  5'd16, 5'd21, 5'd25,
        5'd13, 5'd19, 5'd14, 5'd22, 5'd24, 5'd7,  5'd23, 5'd20, 5'd18, 5'd15,
        5'd0,  5'd8,  5'd1,  5'd17, 5'd2,  5'd9};
    localparam letter_t WIRE_I_INV [26] = '{
        5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25,
        5'd1,  5'd4,  5'd2,  5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11,
        5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9};

    // Rotor II: AJDKSIRUXBLHWTMCQGZNPYFVOE
    localparam letter_t WIRE_II_FWD [26] = '{
        5'd0,  5'd9,  5'd3,  5'd10, 5'd18, 5'd8,  5'd17, 5'd20, 5'd23, 5'd1,
        5'd11, 5'd7,  5'd22, 5'd19, 5'd12, 5'd2,  5'd16, 5'd6,  5'd25, 5'd13,
        5'd15, 5'd24, 5'd5,  5'd21, 5'd14, 5'd4};
    localparam letter_t WIRE_II_INV [26] = '{
        5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,
        5'd3,  5'd10, 5'd14, 5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13,
        5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18};

    // Rotor III: BDFHJLCPRTXVZNYEIWGAKMUSQO
    localparam letter_t WIRE_III_FWD [26] = '{
        5'd1,  5'd3,  5'd5,  5'd7,  5'd9,  5'd11, 5'd2,  5'd15, 5'd17, 5'd19,
        5'd23, 5'd21, 5'd25, 5'd13, 5'd24, 5'd4,  5'd8,  5'd22, 5'd6,  5'd0,
        5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14};
    localparam letter_t WIRE_III_INV [26] = '{
        5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,
        5'd20, 5'd5,  5'd21, 5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,
        5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12};

    // Reflector B: YRUHQSLDPXNGOKMIEBFZCWVJAT
    localparam letter_t REFL_B [26] = '{
        5'd24, 5'd17, 5'd20, 5'd7,  5'd16, 5'd18, 5'd11, 5'd3,  5'd15, 5'd23,
        5'd13, 5'd6,  5'd14, 5'd10, 5'd12, 5'd8,  5'd4,  5'd1,  5'd5,  5'd25,
        5'd2,  5'd22, 5'd21, 5'd9,  5'd0,  5'd19};

    // (a + b) mod 26, computed at 6 bits so the sum never overflows
    function automatic letter_t mod26_add(input letter_t a, input letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= ALPHA_SIZE) begin
            s = s - ALPHA_SIZE;
        end else begin
            s = s;
        end
        return s[4:0];
    endfunction

    // (a - b) mod 26; bias by 26 first so the difference stays non-negative
    function automatic letter_t mod26_sub(input letter_t a, input letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + ALPHA_SIZE - {1'b0, b};
        if (s >= ALPHA_SIZE) begin
            s = s - ALPHA_SIZE;
        end else begin
            s = s;
        end
        return s[4:0];
    endfunction

    // Advance a rotor position by one, wrapping Z back to A
    function automatic letter_t step_pos(input letter_t p);
        if (p == LAST_LETTER) begin
            return 5'd0;
        end else begin
            return p + 5'd1;
        end
    endfunction

    // Raw wiring lookup for one rotor in either direction
    function automatic letter_t rotor_wire(input rotor_id_e id, input logic inv,
                                           input letter_t idx);
        letter_t w;
        case (id)
            ROTOR_I:   w = inv ? WIRE_I_INV[idx]   : WIRE_I_FWD[idx];
            ROTOR_II:  w = inv ? WIRE_II_INV[idx]  : WIRE_II_FWD[idx];
            ROTOR_III: w = inv ? WIRE_III_INV[idx] : WIRE_III_FWD[idx];
            default:   w = idx;
        endcase
        return w;
    endfunction

    function automatic letter_t reflect(input letter_t idx);
        return REFL_B[idx];
    endfunction

endpackage

// File: rtl/enigma_rotor.sv
// enigma_rotor: combinational single pass through one rotor.
// Ports:
//   i_rotor_id  rotor selector (enigma_pkg::rotor_id_e encoding)
//   i_inverse   0 = forward (entry->reflector), 1 = return path
//   i_pos       current rotor position 0..25
//   i_idx       incoming contact index 0..25
//   o_idx       outgoing contact index 0..25
module enigma_rotor
    import enigma_pkg::*;
(
    input  logic [1:0] i_rotor_id,
    input  logic       i_inverse,
    input  logic [4:0] i_pos,
    input  logic [4:0] i_idx,
    output logic [4:0] o_idx
);

    letter_t w_contact;
    letter_t w_wired;

    // Offset into the rotated wiring, look up, then undo the offset
    assign w_contact = mod26_add(i_idx, i_pos);
    assign w_wired   = rotor_wire(rotor_id_e'(i_rotor_id), i_inverse, w_contact);
    assign o_idx     = mod26_sub(w_wired, i_pos);

endmodule

// File: rtl/enigma_1.sv
// enigma_1: Enigma I (rotors I-II-III, reflector B, rings AAA, no plugs).
// Ports:
//   clk_i       clock, rising edge
//   rst_i       asynchronous active-low reset (rotors to AAA, output to 0)
//   in_symb_i   signed plaintext symbol, 1..26 = A..Z, anything else idle
//   out_symb_o  signed ciphertext symbol one cycle later, 0 when idle
// Rotors step before each valid letter is encrypted, so the combinational
// path uses the post-step positions and the same values are registered.
module enigma_1
    import enigma_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic signed [5:0] in_symb_i,
    output logic signed [5:0] out_symb_o
);

    letter_t    r_pos_l;
    letter_t    r_pos_m;
    letter_t    r_pos_r;
    logic [5:0] r_out;

    logic    w_valid;
    letter_t w_in_idx;
    logic    w_step_m;
    logic    w_step_l;
    letter_t w_pos_l_nxt;
    letter_t w_pos_m_nxt;
    letter_t w_pos_r_nxt;
    letter_t w_f_r;
    letter_t w_f_m;
    letter_t w_f_l;
    letter_t w_refl;
    letter_t w_b_l;
    letter_t w_b_m;
    letter_t w_b_r;

    assign w_valid  = (in_symb_i > 6'sd0) && (in_symb_i < 6'sd27);
    assign w_in_idx = in_symb_i[4:0] - 5'd1;

    // Middle rotor at its own notch steps again with the left (double step)
    assign w_step_m = (r_pos_r == NOTCH_III) || (r_pos_m == NOTCH_II);
    assign w_step_l = (r_pos_m == NOTCH_II);

    assign w_pos_r_nxt = step_pos(r_pos_r);
    assign w_pos_m_nxt = w_step_m ? step_pos(r_pos_m) : r_pos_m;
    assign w_pos_l_nxt = w_step_l ? step_pos(r_pos_l) : r_pos_l;

    enigma_rotor u_fwd_r (.i_rotor_id(ROTOR_III), .i_inverse(1'b0), .i_pos(w_pos_r_nxt),
                          .i_idx(w_in_idx), .o_idx(w_f_r));
    enigma_rotor u_fwd_m (.i_rotor_id(ROTOR_II),  .i_inverse(1'b0), .i_pos(w_pos_m_nxt),
                          .i_idx(w_f_r), .o_idx(w_f_m));
    enigma_rotor u_fwd_l (.i_rotor_id(ROTOR_I),   .i_inverse(1'b0), .i_pos(w_pos_l_nxt),
                          .i_idx(w_f_m), .o_idx(w_f_l));

    assign w_refl = reflect(w_f_l);

    enigma_rotor u_inv_l (.i_rotor_id(ROTOR_I),   .i_inverse(1'b1), .i_pos(w_pos_l_nxt),
                          .i_idx(w_refl), .o_idx(w_b_l));
    enigma_rotor u_inv_m (.i_rotor_id(ROTOR_II),  .i_inverse(1'b1), .i_pos(w_pos_m_nxt),
                          .i_idx(w_b_l), .o_idx(w_b_m));
    enigma_rotor u_inv_r (.i_rotor_id(ROTOR_III), .i_inverse(1'b1), .i_pos(w_pos_r_nxt),
                          .i_idx(w_b_m), .o_idx(w_b_r));

    // Rotor positions and registered ciphertext output
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_pos_l <= 5'd0;
            r_pos_m <= 5'd0;
            r_pos_r <= 5'd0;
            r_out   <= 6'd0;
        end else if (w_valid) begin
            r_pos_l <= w_pos_l_nxt;
            r_pos_m <= w_pos_m_nxt;
            r_pos_r <= w_pos_r_nxt;
            r_out   <= {1'b0, w_b_r} + 6'd1;
        end else begin
            r_out   <= 6'd0;
        end
    end

    assign out_symb_o = $signed(r_out);

endmodule

// File: tb/tb_enigma_1.sv
// tb_enigma_1: self-checking bench for enigma_1 against a string-based
// Enigma I reference model (wiring searched directly in the letter strings).
module tb_enigma_1;

    logic              clk_i;
    logic              rst_i;
    logic signed [5:0] in_symb_i;
    logic signed [5:0] out_symb_o;

    int n_tests;
    int n_fail;

    // Reference model state: positions of left (I), middle (II), right (III)
    int mp_l;
    int mp_m;
    int mp_r;

    string ROT_W0 = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    string ROT_W1 = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    string ROT_W2 = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    string REF_B  = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    int plain  [1000];
    int cipher [1000];

    enigma_1 dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_symb_i  (in_symb_i),
        .out_symb_o (out_symb_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int mod26(input int v);
        return ((v % 26) + 26) % 26;
    endfunction

    function automatic int wire_at(input int rid, input int k);
        case (rid)
            0:       return int'(ROT_W0.getc(k)) - 65;
            1:       return int'(ROT_W1.getc(k)) - 65;
            default: return int'(ROT_W2.getc(k)) - 65;
        endcase
    endfunction

    function automatic int pass_fwd(input int rid, input int x, input int p);
        return mod26(wire_at(rid, mod26(x + p)) - p);
    endfunction

    function automatic int pass_inv(input int rid, input int x, input int p);
        int t;
        t = mod26(x + p);
        for (int k = 0; k < 26; k++) begin
            if (wire_at(rid, k) == t) return mod26(k - p);
        end
        return -1;
    endfunction

    // Apply one input to the model: step then encrypt, or 0 for idle values
    task automatic model_apply(input int v, output int res);
        int  x;
        bit  mid, left;
        if (v < 1 || v > 26) begin
            res = 0;
        end else begin
            mid  = (mp_r == 21) || (mp_m == 4);
            left = (mp_m == 4);
            mp_r = (mp_r + 1) % 26;
            if (mid)  mp_m = (mp_m + 1) % 26;
            if (left) mp_l = (mp_l + 1) % 26;
            x = v - 1;
            x = pass_fwd(2, x, mp_r);
            x = pass_fwd(1, x, mp_m);
            x = pass_fwd(0, x, mp_l);
            x = int'(REF_B.getc(x)) - 65;
            x = pass_inv(0, x, mp_l);
            x = pass_inv(1, x, mp_m);
            x = pass_inv(2, x, mp_r);
            res = x + 1;
        end
    endtask

    // Present v for one clock and settle just after the capturing edge
    task automatic drive(input int v);
        @(negedge clk_i);
        in_symb_i = 6'(v);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_chk(input string tag, input int v);
        int exp;
        model_apply(v, exp);
        drive(v);
        check_val(tag, int'(out_symb_o), exp);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i     = 1'b0;
        in_symb_i = 6'($urandom_range(26, 1));
        @(posedge clk_i);
        #1;
        check_val("rst_out", int'(out_symb_o), 0);
        @(negedge clk_i);
        rst_i     = 1'b1;
        in_symb_i = 6'sd0;
        mp_l = 0;
        mp_m = 0;
        mp_r = 0;
    endtask

    initial begin
        int bdzgo [5] = '{2, 4, 26, 7, 15};
        int exp;
        n_tests   = 0;
        n_fail    = 0;
        mp_l      = 0;
        mp_m      = 0;
        mp_r      = 0;
        rst_i     = 1'b0;
        in_symb_i = 6'sd1;

        // Reset held with a valid letter on the input
        repeat (3) @(posedge clk_i);
        #1;
        check_val("por_out", int'(out_symb_o), 0);
        @(negedge clk_i);
        rst_i     = 1'b1;
        in_symb_i = 6'sd0;

        // AAAAA with idle gaps -> BDZGO, zero between letters
        for (int i = 0; i < 5; i++) begin
            drive(1);
            check_val("bdzgo", int'(out_symb_o), bdzgo[i]);
            for (int j = 0; j < 4; j++) begin
                drive(0);
                check_val("bdzgo_gap", int'(out_symb_o), 0);
            end
        end

        // Reciprocity of the first letter
        do_reset();
        drive(2);
        check_val("recip_b", int'(out_symb_o), 1);

        // Invalid symbols neither step nor emit
        do_reset();
        drive(0);
        check_val("inv_0", int'(out_symb_o), 0);
        drive(27);
        check_val("inv_27", int'(out_symb_o), 0);
        drive(-3);
        check_val("inv_m3", int'(out_symb_o), 0);
        drive(1);
        check_val("inv_then_a", int'(out_symb_o), 2);

        // Reset between third and fourth letter of the AAAAA stream
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1);
            check_val("mid_pre", int'(out_symb_o), bdzgo[i]);
        end
        rst_i     = 1'b0;
        in_symb_i = 6'sd1;
        #1;
        check_val("mid_async", int'(out_symb_o), 0);
        @(posedge clk_i);
        #1;
        check_val("mid_hold", int'(out_symb_o), 0);
        @(negedge clk_i);
        rst_i     = 1'b1;
        in_symb_i = 6'sd0;
        drive(1);
        check_val("mid_restart", int'(out_symb_o), 2);

        // 1000 random letters back-to-back vs the model
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            plain[i] = int'($urandom_range(26, 1));
            model_apply(plain[i], exp);
            drive(plain[i]);
            cipher[i] = int'(out_symb_o);
            check_val("rand_model", cipher[i], exp);
            if (cipher[i] == plain[i]) begin
                check_val("rand_self", cipher[i], -plain[i]);
            end
        end
        drive(0);
        check_val("rand_drain", int'(out_symb_o), 0);

        // Ciphertext from AAA decrypts to the plaintext
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            drive(cipher[i]);
            check_val("decrypt", int'(out_symb_o), plain[i]);
        end

        // Random mix of valid and invalid signed values vs the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_chk("mix", int'($urandom_range(63, 0)) - 32);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
